// File: rtl/register_pkg.sv
// register_pkg: project-wide width constants shared by storage elements
package register_pkg;
  localparam int DATA_W = 32;
endpackage

// File: rtl/register.sv
// register: N-bit storage element with write enable and asynchronous active-high reset
module register
  import register_pkg::*;
#(
  parameter int N = DATA_W,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) Q <= RESET_VALUE;
    else if (en) Q <= D;
endmodule

// File: tb/tb_register.sv
// tb_register: directed checks of register at N=32, N=8 and N=1 (all-ones reset for the narrow ones)
module tb_register;
  logic clk, rst, en;
  logic [31:0] d32, q32;
  logic [7:0] d8, q8;
  logic [0:0] d1, q1;
  int checks, errors;

  register u32 (.clk(clk), .rst(rst), .en(en), .D(d32), .Q(q32));
  register #(.N(8), .RESET_VALUE(8'hff)) u8 (.clk(clk), .rst(rst), .en(en), .D(d8), .Q(q8));
  register #(.N(1), .RESET_VALUE(1'b1)) u1 (.clk(clk), .rst(rst), .en(en), .D(d1), .Q(q1));

  initial begin
    clk = 0;
    #100 clk = 1;
    forever #50 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #10;
  endtask

  task automatic chk3(input string tag, input logic [31:0] e32, input logic [7:0] e8, input logic e1);
    check({tag, "_q32"}, q32, e32);
    check({tag, "_q8"}, {24'h0, q8}, {24'h0, e8});
    check({tag, "_q1"}, {31'h0, q1}, {31'h0, e1});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0; en = 0; d32 = '0; d8 = '0; d1 = '0;
    #300 rst = 1;
    #10 chk3("reset_assert", 32'h0, 8'hff, 1'b1);
    #190 rst = 0;
    #10 chk3("reset_release", 32'h0, 8'hff, 1'b1);
    // enable low: D changes must not reach Q
    d32 = 32'h00011111; d8 = 8'h5a; d1 = 1'b0;
    step(); step();
    chk3("hold_en0", 32'h0, 8'hff, 1'b1);
    en = 1; d8 = 8'h3c;
    #1 chk3("no_comb_path", 32'h0, 8'hff, 1'b1);
    step();
    chk3("write1", 32'h00011111, 8'h3c, 1'b0);
    step();
    chk3("write1_again", 32'h00011111, 8'h3c, 1'b0);
    en = 0; step();
    chk3("hold_after_write", 32'h00011111, 8'h3c, 1'b0);
    en = 1; step();
    chk3("rewrite_same", 32'h00011111, 8'h3c, 1'b0);
    d32 = 32'h000AAAAA; d8 = 8'ha5; d1 = 1'b1; step();
    chk3("write2", 32'h000AAAAA, 8'ha5, 1'b1);
    en = 0; d32 = 32'h00012345; d8 = 8'h00; d1 = 1'b0; step();
    chk3("hold2", 32'h000AAAAA, 8'ha5, 1'b1);
    // asynchronous reset landing mid-cycle
    #27 rst = 1;
    #1 chk3("async_reset", 32'h0, 8'hff, 1'b1);
    en = 1; d32 = 32'h00055555; d8 = 8'h11; d1 = 1'b0;
    step();
    chk3("reset_dominates", 32'h0, 8'hff, 1'b1);
    rst = 0;
    d32 = 32'h00044444; d8 = 8'h44; d1 = 1'b0; step();
    chk3("b2b_1", 32'h00044444, 8'h44, 1'b0);
    d32 = 32'h00077777; d8 = 8'h77; d1 = 1'b1; step();
    chk3("b2b_2", 32'h00077777, 8'h77, 1'b1);
    d32 = 32'h00022222; d8 = 8'h22; d1 = 1'b0; step();
    chk3("b2b_3", 32'h00022222, 8'h22, 1'b0);
    en = 0; d32 = 32'h000EEEEE; d8 = 8'hee; d1 = 1'b1; step();
    chk3("b2b_hold1", 32'h00022222, 8'h22, 1'b0);
    d32 = 32'h0; d8 = 8'h00; step();
    chk3("b2b_hold2", 32'h00022222, 8'h22, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register.md
Name: register

Overview:
- Parameterised N-bit storage element with write enable, asynchronous active-high reset and one clock.
- Generic building block used throughout the microarchitecture: pipeline registers, program counter, special-purpose and state registers.
- Holds its value until it is written or reset.

Parameters:
- N, 32, data width in bits; legal range 1 and up.
- RESET_VALUE, '0 (N bits), value loaded into Q while rst is asserted.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  write enable, sampled on the rising clk edge.
- D  input  N  data to be stored.
- Q  output  N  stored value, driven directly from the storage flops.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset:
  - Q goes to RESET_VALUE (0 by default) immediately when rst rises. No clock edge is needed.
  - Q stays at RESET_VALUE for as long as rst is high, whatever en and D are doing.
- Reset dominates: if rst and en are both high at a clock edge, Q stays at RESET_VALUE.
- Reset release: the first rising edge after rst falls behaves as a normal edge. If en=1 at that edge, D is captured.
- Write: on a rising clk edge with rst=0 and en=1, Q takes the value of D.
  - Latency is one edge. The new value is visible just after that edge and holds until the next qualifying event.
- Hold: on a rising clk edge with rst=0 and en=0, Q keeps its previous value.
  - Changes on D while en=0 have no effect on Q.
- Enable held high: Q follows D edge by edge, with a one-cycle delay.
- No combinational path from D or en to Q. Q changes only on a clock edge or on rst rising.
- Power-up before the first reset: Q is undefined. The system guarantees a reset before use.
- en=X or D=X in simulation: no special handling is required.
- Width rule: all N bits are stored and reset together. There is no partial or byte-wise write.

Decomposition:
- Single module; no sub-modules.
- No package content is needed.
- The default width 32 may be referenced from the project-wide width constants in the shared package, if one exists.
- Wider composite registers, such as pipeline stage registers, instantiate this module or arrays of it.

Test Plan:
Clock period 100 with rising edges at 100, 200, …; en=0 and D=0 at the start unless stated.
1. Reset: rst=1 from t=300 to 500 with D=0, en=0 → Q=0x00000000 from the moment rst rises. Q stays 0 after release.
2. Hold with enable low: D=0x00011111, en=0 for two edges → Q stays 0x00000000.
3. Write and hold:
   - en=1 for two edges with D=0x00011111 → Q=0x00011111 after the first edge.
   - en=0, then en=1 again with the same D → Q stays 0x00011111.
   - D=0x000AAAAA with en=1 → Q=0x000AAAAA after the next edge.
   - en=0 → Q holds 0x000AAAAA.
4. Asynchronous reset mid-operation: Q=0x000AAAAA, rst pulsed high at a point not aligned to any clock edge → Q=0 immediately, with no edge required. Asserting en=1 during reset keeps Q=0.
5. Back-to-back writes:
   - After reset release, en=1 with D=0x00044444, then 0x00077777, then 0x00022222, one value per cycle → Q follows each value one edge later.
   - en=0 with D=0x000EEEEE, then D=0x00000000 → Q holds 0x00022222.
6. Parameter sweep: N=1 and N=8 with RESET_VALUE=all ones → reset drives Q to all ones, and write and hold behave identically to N=32.
